// File: rtl/iobuf_input_capture.sv
// Input capture for buffered IO pins: synchronizes din, detects changes and queues
// timestamped {ts, pins} records in a FIFO. Define IOBUF_CAPTURE_FILTER_EN to add a per-pin glitch filter.
module iobuf_input_capture #(
  parameter int WIDTH      = 2,
  parameter int TS_W       = 16,
  parameter int DEPTH      = 16,
  parameter int FILTER_LEN = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clear,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        pin_oe,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [TS_W+WIDTH-1:0]   out_data,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = TS_W + WIDTH;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || FILTER_LEN < 1) begin : g_param_check
    $error("iobuf_input_capture: DEPTH must be a power of 2 >= 2 and FILTER_LEN >= 1");
  end

  logic [WIDTH-1:0] s1, s2, prev, cmp;
  logic             en_d;
  logic [TS_W-1:0]  ts;
  logic             rise, change, push_req, push_ok, pop, full;
  logic [RW-1:0]    push_rec;

  logic [RW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;

  // The block only ever listens; the tristate array keeps every pin as an input.
  assign pin_oe = '0;

  assign rise     = en & ~en_d;
  assign change   = en & ~rise & (cmp != prev);
  assign push_req = ~clear & (rise | change);
  assign push_rec = rise ? {{TS_W{1'b0}}, s2} : {ts, cmp};
  assign full     = (count == CW'(DEPTH));
  assign pop      = out_valid & out_ready;
  assign push_ok  = push_req & (~full | pop);

  assign out_valid  = (count != '0);
  assign out_data   = out_valid ? mem[rd_ptr] : '0;
  assign fifo_count = count;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
      en_d <= 1'b0;
      ts   <= '0;
    end else begin
      s1   <= din;
      s2   <= s1;
      en_d <= en;
      if (clear) begin
        ts   <= '0;
        prev <= s2;
      end else begin
        if (rise)      ts <= '0;
        else if (en)   ts <= ts + TS_W'(1);
        if (rise)        prev <= s2;
        else if (change) prev <= cmp;
      end
    end
  end

`ifdef IOBUF_CAPTURE_FILTER_EN
  localparam int FCW = $clog2(FILTER_LEN + 1);

  logic [WIDTH-1:0] filt;
  logic [FCW-1:0]   fcnt [WIDTH];

  // A pin's filtered value follows s2 only after FILTER_LEN consecutive differing cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt <= '0;
      for (int i = 0; i < WIDTH; i++) fcnt[i] <= '0;
    end else if (clear || rise) begin
      filt <= s2;
      for (int i = 0; i < WIDTH; i++) fcnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s2[i] != filt[i]) begin
          if (fcnt[i] == FCW'(FILTER_LEN - 1)) begin
            filt[i] <= s2[i];
            fcnt[i] <= '0;
          end else begin
            fcnt[i] <= fcnt[i] + FCW'(1);
          end
        end else begin
          fcnt[i] <= '0;
        end
      end
    end
  end

  assign cmp = filt;
`else
  assign cmp = s2;
`endif

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop)      count <= count + CW'(1);
      else if (!push_ok && pop) count <= count - CW'(1);
      if (push_req && full && !pop) overflow <= 1'b1;
    end
  end

  // NOTE: record storage has no reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_rec;
  end

endmodule
